// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
// Module   : fetcher
// Purpose  : Instruction fetch unit. Holds the fetch PC, looks it up in a
//            direct-mapped one-word-per-line instruction cache, fills misses
//            from the memory controller and offers one instruction at a time
//            to the decoder. Redirects on ROB flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetcher #(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          ICACHE_IDX_BIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  // decoder side
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        f_ok,
  input  logic [31:0] f_next_pc,
  // ROB flush
  input  logic        clear_in,
  input  logic [31:0] clear_pc,
  // memory controller side
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int LINES = 1 << ICACHE_IDX_BIT;
  localparam int TAG_W = 30 - ICACHE_IDX_BIT;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_OFFER = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [31:0]         r_pc, w_pc;
  logic                r_inst_valid, w_inst_valid;
  logic [31:0]         r_inst_addr, w_inst_addr;
  logic [31:0]         r_inst_data, w_inst_data;
  logic                r_req_valid, w_req_valid;
  logic [31:0]         r_req_addr, w_req_addr;
  logic                w_fill;

  // cache storage: only the valid bits need a reset value
  logic [LINES-1:0]    r_line_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // lookup uses the current PC; fill uses the outstanding request address,
  // which stays correct even after a flush has moved the PC (DRAIN)
  logic [ICACHE_IDX_BIT-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0]          w_tag, w_fill_tag;
  logic                      w_hit;

  assign w_idx      = r_pc[ICACHE_IDX_BIT+1:2];
  assign w_tag      = r_pc[31:ICACHE_IDX_BIT+2];
  assign w_fill_idx = r_req_addr[ICACHE_IDX_BIT+1:2];
  assign w_fill_tag = r_req_addr[31:ICACHE_IDX_BIT+2];
  assign w_hit      = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign inst_valid    = r_inst_valid;
  assign inst_addr     = r_inst_addr;
  assign inst_data     = r_inst_data;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;

  // next-state and output logic; everything holds while rdy_in is low
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_inst_valid = r_inst_valid;
    w_inst_addr  = r_inst_addr;
    w_inst_data  = r_inst_data;
    w_req_valid  = r_req_valid;
    w_req_addr   = r_req_addr;
    w_fill       = 1'b0;

    if (rdy_in) begin
      case (r_state)
        S_FETCH: begin
          if (w_hit) begin
            w_inst_data  = r_data[w_idx];
            w_inst_addr  = r_pc;
            w_inst_valid = 1'b1;
            w_state      = S_OFFER;
          end else begin
            w_req_valid = 1'b1;
            w_req_addr  = {r_pc[31:2], 2'b00};
            w_state     = S_MISS;
          end
        end
        S_MISS: begin
          if (mem_resp_valid) begin
            w_fill       = 1'b1;
            w_req_valid  = 1'b0;
            w_inst_data  = mem_resp_data;
            w_inst_addr  = r_pc;
            w_inst_valid = 1'b1;
            w_state      = S_OFFER;
          end
        end
        S_OFFER: begin
          if (f_ok) begin
            w_pc         = f_next_pc;
            w_inst_valid = 1'b0;
            w_state      = S_FETCH;
          end
        end
        S_DRAIN: begin
          // the stale word still fills the cache, but is never offered
          if (mem_resp_valid) begin
            w_fill      = 1'b1;
            w_req_valid = 1'b0;
            w_state     = S_FETCH;
          end
        end
        default: w_state = S_FETCH;
      endcase

      // a flush overrides whatever the state logic decided (including f_ok)
      if (clear_in) begin
        w_pc         = clear_pc;
        w_inst_valid = 1'b0;
        case (r_state)
          S_FETCH: begin
            // suppress the lookup of the discarded PC
            w_state     = S_FETCH;
            w_req_valid = r_req_valid;
            w_req_addr  = r_req_addr;
            w_inst_addr = r_inst_addr;
            w_inst_data = r_inst_data;
          end
          S_OFFER: w_state = S_FETCH;
          default: begin
            // an outstanding request must complete before refetching
            w_state = mem_resp_valid ? S_FETCH : S_DRAIN;
          end
        endcase
      end
    end
  end

  // state, output and line-valid registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_addr  <= 32'h0;
      r_inst_data  <= 32'h0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= 32'h0;
      r_line_valid <= '0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_inst_valid <= w_inst_valid;
      r_inst_addr  <= w_inst_addr;
      r_inst_data  <= w_inst_data;
      r_req_valid  <= w_req_valid;
      r_req_addr   <= w_req_addr;
      if (w_fill) begin
        r_line_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // tag and data arrays written on a fill
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetcher
// Purpose  : Self-checking bench for fetcher: table of fetch vectors plus
//            hand sequences for flush, stall and reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        f_ok;
  logic [31:0] f_next_pc;
  logic        clear_in;
  logic [31:0] clear_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] pc;
    bit          miss;
    int          delay;
    int          hold;
  } vec_t;
  vec_t tbl[11];

  fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_BIT(4)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .inst_valid     (inst_valid),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .f_ok           (f_ok),
    .f_next_pc      (f_next_pc),
    .clear_in       (clear_in),
    .clear_pc       (clear_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  // memory contents seen by the fetcher
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00500093;
    else if (a == 32'h8) return 32'h12345678;
    else                 return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_offer(input string name, input exp_t e);
    check({name, "_valid"}, {31'd0, inst_valid}, 32'd1);
    check({name, "_addr"}, inst_addr, e.addr);
    check({name, "_data"}, inst_data, e.data);
  endtask

  // entered at a falling edge with the DUT in FETCH at pc
  task automatic do_fetch(input logic [31:0] pc, input bit miss, input int delay, input int hold);
    logic [31:0] waddr;
    exp_t        e;
    waddr = {pc[31:2], 2'b00};
    sb.push_back('{addr: pc, data: mem_word(waddr)});
    check("gap_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    check("miss_req", {31'd0, mem_req_valid}, {31'd0, miss});
    if (miss) begin
      check("req_addr", mem_req_addr, waddr);
      check("miss_no_offer", {31'd0, inst_valid}, 32'd0);
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        check("req_held", {31'd0, mem_req_valid}, 32'd1);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(waddr);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hDEAD_BEEF;
      check("req_drop", {31'd0, mem_req_valid}, 32'd0);
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL sb_empty: got offer at %h expected none", inst_addr);
    end else begin
      e = sb.pop_front();
      check_offer("offer", e);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check_offer("hold", e);
      end
    end
  endtask

  task automatic accept(input logic [31:0] next);
    f_ok      = 1'b1;
    f_next_pc = next;
    @(negedge clk);
    f_ok      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tbl[0]  = '{pc: 32'h00, miss: 1'b1, delay: 3, hold: 0};  // cold start
    tbl[1]  = '{pc: 32'h04, miss: 1'b1, delay: 0, hold: 0};
    tbl[2]  = '{pc: 32'h00, miss: 1'b0, delay: 0, hold: 0};  // hit after fill
    tbl[3]  = '{pc: 32'h04, miss: 1'b0, delay: 0, hold: 2};  // offer held
    tbl[4]  = '{pc: 32'h40, miss: 1'b1, delay: 1, hold: 0};  // conflict idx 0
    tbl[5]  = '{pc: 32'h00, miss: 1'b1, delay: 0, hold: 0};  // line replaced
    tbl[6]  = '{pc: 32'h3C, miss: 1'b1, delay: 2, hold: 0};  // last index
    tbl[7]  = '{pc: 32'h7C, miss: 1'b1, delay: 0, hold: 0};
    tbl[8]  = '{pc: 32'h3C, miss: 1'b1, delay: 0, hold: 0};
    tbl[9]  = '{pc: 32'h02, miss: 1'b0, delay: 0, hold: 1};  // pc[1:0] ignored
    tbl[10] = '{pc: 32'h7C, miss: 1'b1, delay: 0, hold: 0};

    rst_n = 1'b0; rdy = 1'b1; f_ok = 1'b0; f_next_pc = 32'h0;
    clear_in = 1'b0; clear_pc = 32'h0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;

    @(negedge clk);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_fetch(tbl[i].pc, tbl[i].miss, tbl[i].delay, tbl[i].hold);
      accept((i < 10) ? tbl[i+1].pc : 32'h8);
    end

    // flush during a miss: response fills the cache but is not offered
    @(negedge clk);
    check("drain_req", {31'd0, mem_req_valid}, 32'd1);
    check("drain_req_addr", mem_req_addr, 32'h8);
    clear_in = 1'b1; clear_pc = 32'h100;
    @(negedge clk);
    clear_in = 1'b0;
    check("drain_no_offer", {31'd0, inst_valid}, 32'd0);
    check("drain_req_kept", {31'd0, mem_req_valid}, 32'd1);
    check("drain_addr_kept", mem_req_addr, 32'h8);
    @(negedge clk);
    check("drain_req_kept2", {31'd0, mem_req_valid}, 32'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("drain_resp_no_offer", {31'd0, inst_valid}, 32'd0);
    check("drain_req_drop", {31'd0, mem_req_valid}, 32'd0);
    do_fetch(32'h100, 1'b1, 0, 0);
    accept(32'h8);
    do_fetch(32'h8, 1'b0, 0, 0);     // drained word is now cached

    // clear and f_ok together: clear wins
    f_ok = 1'b1; f_next_pc = 32'h20;
    clear_in = 1'b1; clear_pc = 32'h80;
    @(negedge clk);
    f_ok = 1'b0; clear_in = 1'b0;
    do_fetch(32'h80, 1'b1, 0, 0);

    // stall in OFFER: f_ok, clear_in and a stray response are all ignored
    e = '{addr: 32'h80, data: mem_word(32'h80)};
    rdy = 1'b0; f_ok = 1'b1; f_next_pc = 32'h4;
    clear_in = 1'b1; clear_pc = 32'h100;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_offer("stall", e);
      check("stall_req", {31'd0, mem_req_valid}, 32'd0);
    end
    rdy = 1'b1; clear_in = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    f_ok = 1'b0;
    do_fetch(32'h4, 1'b0, 0, 0);

    // response with nothing pending must not touch the cache
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD1_BAD1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    accept(32'h80);
    do_fetch(32'h80, 1'b0, 0, 0);

    // asynchronous reset in the middle of a miss
    accept(32'hC);
    @(negedge clk);
    check("pre_rst_req", {31'd0, mem_req_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_inst_addr", inst_addr, 32'h0);
    check("arst_inst_data", inst_data, 32'h0);
    check("arst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("arst_req_addr", mem_req_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(32'h0, 1'b1, 1, 0);     // cache invalidated: refetch misses

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
